// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the carry-save stream accumulator.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } acc_state_e;

    localparam int unsigned COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(255);

    // Number of cycles the final carry-propagate takes
    function automatic int unsigned chunk_count(input int unsigned acc_w, input int unsigned chunk_w);
        return acc_w / chunk_w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out stream bundle of the accumulator.
// out_ovf exists only when CSA_ACC_OVF_EN is defined.
interface csa_stream_accumulator_if
    import csa_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;
`ifdef CSA_ACC_OVF_EN
    logic               out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
`endif

endinterface

// File: rtl/csa_fa.sv
// Single-bit full adder used as the cell of the 3:2 compressor row.
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_row.sv
// ACC_W-wide 3:2 carry-save compressor; carry vector is returned unshifted.
module csa_row #(
    parameter int unsigned ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] maj_o
);
    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        csa_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .c  (c[i]),
            .s  (sum_o[i]),
            .co (maj_o[i])
        );
    end
endmodule

// File: rtl/csa_stream_accumulator.sv
// Carry-save stream accumulator: sums a packet in redundant form, then resolves it chunk by chunk.
// Optional sticky overflow output enabled by defining CSA_ACC_OVF_EN.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned CPA_CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    csa_stream_accumulator_if.slave  bus
);
    localparam int unsigned K     = chunk_count(ACC_W, CPA_CHUNK);
    localparam int unsigned IDX_W = idx_width(K);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    acc_state_e                   state_q, state_d;
    logic [ACC_W-1:0]             s_q, s_d;
    logic [ACC_W-1:0]             c_q, c_d;
    logic [COUNT_W-1:0]           count_q, count_d;
    logic [K-1:0][CPA_CHUNK-1:0]  sum_q, sum_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         cy_q, cy_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
`ifdef CSA_ACC_OVF_EN
    logic                         ovf_q, ovf_d;
`endif

    logic [ACC_W-1:0]             x_ext;
    logic [ACC_W-1:0]             row_sum;
    logic [ACC_W-1:0]             row_maj;
    logic [K-1:0][CPA_CHUNK-1:0]  s_vec;
    logic [K-1:0][CPA_CHUNK-1:0]  c_vec;
    logic [CPA_CHUNK:0]           chunk_add;

    assign x_ext = ACC_W'(bus.in_data);

    csa_row #(.ACC_W(ACC_W)) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (x_ext),
        .sum_o (row_sum),
        .maj_o (row_maj)
    );

    // One slice of the final carry-propagate add per RESOLVE cycle
    assign s_vec     = s_q;
    assign c_vec     = c_q;
    assign chunk_add = {1'b0, s_vec[idx_q]} + {1'b0, c_vec[idx_q]} + (CPA_CHUNK + 1)'(cy_q);

`ifndef CSA_ACC_OVF_EN
    logic unused_ovf_bits;
    assign unused_ovf_bits = row_maj[ACC_W-1];
`endif

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        count_d   = count_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
`ifdef CSA_ACC_OVF_EN
        ovf_d     = ovf_q;
`endif

        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    s_d     = row_sum;
                    c_d     = {row_maj[ACC_W-2:0], 1'b0};
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = ovf_q | row_maj[ACC_W-1];
`endif
                    if (bus.in_last) begin
                        state_d = RESOLVE;
                        idx_d   = '0;
                        cy_d    = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                sum_d[idx_q] = chunk_add[CPA_CHUNK-1:0];
                cy_d         = chunk_add[CPA_CHUNK];
                if (idx_q == IDX_LAST) begin
                    state_d = HOLD;
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = ovf_q | chunk_add[CPA_CHUNK];
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: state_d = ACCUM;
        endcase

        // Handshake flags are registered copies of the next-state decode
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            cy_q        <= cy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
`ifdef CSA_ACC_OVF_EN
    assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Randomised bench for csa_stream_accumulator checked against a packet-level arithmetic model.
module tb_csa_stream_accumulator;
    import csa_acc_pkg::*;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned ACC_W     = 8;
    localparam int unsigned CPA_CHUNK = 4;
    localparam int         K         = ACC_W / CPA_CHUNK;
    localparam int         MODV      = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_stream_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CPA_CHUNK(CPA_CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } res_t;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    int   m_total, m_n, resolve_left;
    bit   have_result;
    int   negcnt, last_acc_neg, lat;
    bit   lat_pending;
    int   n_out;
    int   got_sum, got_cnt;
    bit   got_ovf;
    int   ordy_mode = 1;
    int   pkt[$];

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Packet-level model: a result appears K edges after the last accept and waits for out_ready
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_out_valid", bus.out_valid, 0);
            m_total = 0; m_n = 0; resolve_left = 0; have_result = 0;
            lat_pending = 0;
            exp_q.delete();
        end else begin
            chk("in_ready", bus.in_ready, (resolve_left == 0 && !have_result) ? 1 : 0);
            chk("out_valid", bus.out_valid, have_result ? 1 : 0);
            if (have_result && bus.out_valid && exp_q.size() > 0) begin
                chk("out_sum", bus.out_sum, exp_q[0].sum);
                chk("out_count", bus.out_count, exp_q[0].cnt);
`ifdef CSA_ACC_OVF_EN
                chk("out_ovf", bus.out_ovf, exp_q[0].ovf);
`endif
            end
            if (lat_pending && bus.out_valid) begin
                lat = negcnt - last_acc_neg;
                lat_pending = 0;
            end
            if (have_result) begin
                if (bus.out_ready) begin
                    got_sum = int'(bus.out_sum);
                    got_cnt = int'(bus.out_count);
`ifdef CSA_ACC_OVF_EN
                    got_ovf = bus.out_ovf;
`else
                    got_ovf = 1'b0;
`endif
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    have_result = 0;
                    n_out++;
                end
            end else if (resolve_left > 0) begin
                resolve_left--;
                if (resolve_left == 0) have_result = 1;
            end else if (bus.in_valid) begin
                m_total += int'(bus.in_data);
                m_n++;
                if (bus.in_last) begin
                    exp_q.push_back('{sum: m_total % MODV, cnt: (m_n > 255) ? 255 : m_n,
                                      ovf: (m_total >= MODV)});
                    m_total = 0; m_n = 0;
                    resolve_left = K;
                    last_acc_neg = negcnt;
                    lat_pending = 1;
                end
            end
        end
        negcnt++;
    end

    // Consumer side: constant or random out_ready
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = (ordy_mode == 2) ? 1'($urandom) : 1'(ordy_mode);
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // While blocked, present garbage that the DUT must ignore
    task automatic wait_ready();
        int b = 0;
        while (!bus.in_ready && b < 200) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = WIDTH'($urandom);
            bus.in_last  = 1'($urandom);
            tick();
            b++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic beat(input int d, input bit last, input int gap_max);
        bus.in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) tick();
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'(d);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = WIDTH'($urandom);
    endtask

    task automatic send_pkt(input int gap_max);
        foreach (pkt[i]) beat(pkt[i], (i == pkt.size() - 1), gap_max);
    endtask

    task automatic wait_out(input int target);
        int b = 0;
        while (n_out < target && b < 400) begin
            tick();
            b++;
        end
        chk("result_timeout", n_out, target);
    endtask

    initial begin
        int b;
        int sum260;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sum", bus.out_sum, 0);
        chk("reset_out_count", bus.out_count, 0);
        rst_n = 1'b1;
        tick();

        pkt = {15, 15, 15};
        send_pkt(0);
        wait_out(1);
        chk("t1_sum", got_sum, 45);
        chk("t1_count", got_cnt, 3);
        chk("t1_latency", lat, K + 1);
`ifdef CSA_ACC_OVF_EN
        chk("t1_ovf", got_ovf, 0);
`endif

        pkt = {9};
        send_pkt(0);
        wait_out(2);
        chk("t2_sum", got_sum, 9);
        chk("t2_count", got_cnt, 1);

        pkt.delete();
        for (int i = 0; i < 18; i++) pkt.push_back(15);
        send_pkt(0);
        wait_out(3);
        chk("t3_sum", got_sum, 14);
        chk("t3_count", got_cnt, 18);
`ifdef CSA_ACC_OVF_EN
        chk("t3_ovf", got_ovf, 1);
`endif

        pkt = {1, 2, 3, 4, 5, 6};
        send_pkt(3);
        wait_out(4);
        chk("t4_sum", got_sum, 21);
        chk("t4_count", got_cnt, 6);

        ordy_mode = 0;
        tick();
        pkt = {2, 5};
        send_pkt(0);
        b = 0;
        while (!bus.out_valid && b < 50) begin tick(); b++; end
        chk("t5_valid_seen", bus.out_valid, 1);
        repeat (5) begin
            tick();
            chk("t5_hold_in_ready", bus.in_ready, 0);
            chk("t5_hold_valid", bus.out_valid, 1);
            chk("t5_hold_sum", bus.out_sum, 7);
            chk("t5_hold_count", bus.out_count, 2);
        end
        ordy_mode = 1;
        wait_out(5);
        chk("t5_in_ready_after_hs", bus.in_ready, 1);
        chk("t5_sum", got_sum, 7);
        pkt = {1, 2};
        send_pkt(0);
        wait_out(6);
        chk("t5_next_sum", got_sum, 3);
        chk("t5_next_count", got_cnt, 2);

        pkt = {5, 6};
        send_pkt(0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", bus.in_ready, 1);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_out_count", bus.out_count, 0);
        @(posedge clk); #1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_result", n_out, 6);
        pkt = {7};
        send_pkt(0);
        wait_out(7);
        chk("t6_sum", got_sum, 7);
        chk("t6_count", got_cnt, 1);

        pkt.delete();
        sum260 = 0;
        for (int i = 0; i < 260; i++) begin
            pkt.push_back(int'($urandom_range(15, 0)));
            sum260 += pkt[i];
        end
        send_pkt(0);
        wait_out(8);
        chk("t7_sat_count", got_cnt, 255);
        chk("t7_sum", got_sum, sum260 % MODV);

        ordy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(12, 1));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(int'($urandom_range(15, 0)));
            send_pkt(2);
        end
        wait_out(48);
        ordy_mode = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
